// File: rtl/audio_sample_fifo_out_if.sv
// Write-side handshake bundle for audio_sample_fifo_out: frame, request and FIFO-not-full.
interface audio_sample_fifo_out_if #(
  parameter int AUDIO_BITS = 12,
  parameter int CHANNELS   = 2
);
  logic                           wreq;
  logic [CHANNELS*AUDIO_BITS-1:0] sample;
  logic                           ready;

  modport master (output wreq, output sample, input ready);
  modport slave  (input wreq, input sample, output ready);
endinterface

// File: rtl/audio_sample_fifo_out.sv
// Multichannel PCM output stage: buffers system-side frames and releases one per
// sample period to the DSM inputs, with sticky underrun/overflow reporting.
module audio_sample_fifo_out #(
  parameter int AUDIO_BITS    = 12,
  parameter int CHANNELS      = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int PERIOD_BITS   = 12,
  parameter int MIDSCALE_IDLE = 0,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                           clk_audio,
  input  logic                           aclr,
  audio_sample_fifo_out_if.slave         wr,
  input  logic                           status_clr,
  output logic [CHANNELS*AUDIO_BITS-1:0] pcm_out,
  output logic                           sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           underrun,
  output logic                           overflow
);

  localparam int FW = CHANNELS * AUDIO_BITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [AUDIO_BITS-1:0] IDLE_SAMPLE =
    (MIDSCALE_IDLE != 0) ? {1'b1, {(AUDIO_BITS-1){1'b0}}} : '0;
  localparam logic [FW-1:0] IDLE_FRAME = {CHANNELS{IDLE_SAMPLE}};

  logic [PERIOD_BITS-1:0] period_cnt;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [FW-1:0]          mem [FIFO_DEPTH];
  logic                   boundary;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign boundary = (period_cnt == '0);
  assign empty    = (level == '0);
  assign wr.ready = (level != DEPTH_L);
  // ready reflects the pre-edge count, so a full FIFO drops a write even when a pop frees a slot
  assign push     = wr.wreq && wr.ready;
  assign pop      = boundary && !empty;

  always_ff @(posedge clk_audio or posedge aclr) begin
    if (aclr) period_cnt <= '0;
    else      period_cnt <= period_cnt + PERIOD_BITS'(1);
  end

  // Storage carries no reset so it can map onto RAM; pointers and level define validity
  always_ff @(posedge clk_audio) begin
    if (push) mem[wr_ptr] <= wr.sample;
  end

  always_ff @(posedge clk_audio or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_audio or posedge aclr) begin
    if (aclr) begin
      pcm_out     <= IDLE_FRAME;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= boundary;
      if (pop)
        pcm_out <= mem[rd_ptr];
      else if (boundary && UNDERRUN_HOLD == 0)
        pcm_out <= IDLE_FRAME;
    end
  end

  // A set event on the same edge as status_clr leaves the flag set
  always_ff @(posedge clk_audio or posedge aclr) begin
    if (aclr) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= (boundary && empty) || (underrun && !status_clr);
      overflow <= (wr.wreq && !wr.ready) || (overflow && !status_clr);
    end
  end

endmodule

// File: doc/audio_sample_fifo_out.md
Name: audio_sample_fifo_out

Overview:
- Parametrised multichannel PCM output stage for the 1-bit DSM audio path.
- Buffers frames written by the system side in a FIFO, running entirely in the clk_audio domain.
- Releases one frame to the per-channel DSM inputs once per sample period.
- Adds underrun/overflow reporting, a configurable idle code and a hold-on-underrun mode.

Parameters:
- AUDIO_BITS, 12, bits per channel sample.
- CHANNELS, 2, channel count (1..8); frame width = CHANNELS*AUDIO_BITS.
- FIFO_DEPTH, 8, frames buffered; power of two, 2..64.
- PERIOD_BITS, 12, sample period = 2^PERIOD_BITS clk_audio cycles.
- MIDSCALE_IDLE, 0, 0: idle code is all zeros; 1: idle code is 2^(AUDIO_BITS-1) (unsigned DSM silence).
- UNDERRUN_HOLD, 0, 0: output idle code on underrun; 1: repeat last frame.

Ports:
- clk_audio, in, 1: audio clock (44.1 kHz * 2^PERIOD_BITS).
- aclr, in, 1: reset; asynchronous, active-high.
- wreq, in, 1: write request; frame accepted on a rising edge when wreq && ready.
- sample, in, CHANNELS*AUDIO_BITS: frame; channel 0 in the MSBs, channel CHANNELS-1 in the LSBs.
- ready, out, 1: FIFO not full.
- status_clr, in, 1: clears the sticky flags.
- pcm_out, out, CHANNELS*AUDIO_BITS: current frame to the DSMs, same packing as sample.
- sample_tick, out, 1: one-cycle pulse, high in the cycle in which pcm_out holds a newly loaded value.
- level, out, $clog2(FIFO_DEPTH)+1: frames currently stored.
- underrun, out, 1: sticky; a period boundary occurred with the FIFO empty.
- overflow, out, 1: sticky; wreq was asserted while ready=0.

Behaviour:
- Reset (aclr high, async), all outputs/state:
  - pcm_out = idle code in every channel
  - level = 0, ready = 1
  - sample_tick = 0, underrun = 0, overflow = 0
  - period counter = 0, FIFO pointers = 0
  - Reset mid-operation discards all buffered frames.
- Period counter:
  - PERIOD_BITS wide, increments every edge, wraps 2^PERIOD_BITS-1 -> 0.
  - "Boundary edge" = an edge at which the pre-edge counter value is 0.
  - The first boundary is the first edge after aclr deasserts.
- ready = (level != FIFO_DEPTH), combinational from the registered count.
- Write:
  - At an edge with wreq && ready, the frame is pushed.
  - wreq with ready=0: frame dropped, overflow set.
- Boundary edge, level > 0 (pre-edge):
  - Oldest frame is popped into pcm_out.
- Boundary edge, level == 0 (pre-edge):
  - underrun set.
  - pcm_out = idle code (UNDERRUN_HOLD=0) or unchanged (UNDERRUN_HOLD=1).
  - A frame written at that same edge is not bypassed; it is stored and played at the next boundary.
- Push and pop on the same edge:
  - Both occur; level unchanged.
  - On a full FIFO, ready=0 pre-edge, so the write is dropped even though a pop frees a slot.
- Latency:
  - pcm_out and sample_tick update on the boundary edge itself.
  - A write into an empty FIFO therefore appears at pcm_out 1..2^PERIOD_BITS cycles later.
- sample_tick: registered, high for exactly the one cycle after every boundary edge, including underrun boundaries.
- pcm_out changes only at boundary edges and reset.
- Sticky flags:
  - status_clr at an edge clears both flags.
  - A set event on the same edge wins (flag stays 1).
- Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH or goes below 0.
- Storage: register array or inferred RAM. Read data must be valid at the boundary edge; no extra read-latency cycle is visible at pcm_out.

Test Plan:
- Reset release, no writes (defaults, MIDSCALE_IDLE=1):
  - pcm_out = 0x800_800, sample_tick pulses at cycles 1, 4097, ...
  - underrun = 1 after the first boundary; level = 0; ready = 1.
- Write 0xABC_123 one cycle after a boundary:
  - level = 1.
  - At the next boundary, pcm_out = 0xABC_123, level = 0.
  - pcm_out holds that value for 4096 cycles.
- Burst 9 writes, one per cycle (FIFO_DEPTH=8), between boundaries:
  - ready falls after the 8th write, and the 9th write is dropped.
  - overflow = 1, level = 8.
  - The next 8 boundaries emit frames 1..8 in order.
- Underrun hold, UNDERRUN_HOLD=1:
  - One frame 0x111_222, then none: pcm_out stays 0x111_222 and underrun sets.
  - With UNDERRUN_HOLD=0 and MIDSCALE_IDLE=0, pcm_out goes to 0x000_000 at the second boundary.
- Same-edge events:
  - Write on a boundary edge with level=0: underrun sets, level = 1, frame appears one period later.
  - status_clr asserted on the same edge as an overflow event: overflow remains 1.
- aclr pulsed mid-period with level = 5:
  - Immediately pcm_out = idle code, level = 0, flags = 0.
  - First boundary is the first edge after release.
